// File: rtl/bitwise_pkg.sv
// Shared constants for the bitwise operation scheduler: opcodes, FSM states, default widths.
package bitwise_pkg;

  localparam int unsigned DEF_W = 4;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_lane.sv
// Shared combinational bitwise unit; the reserved opcode yields zero and flags an error.
module bitwise_lane
  import bitwise_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned OPW = OP_W
) (
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic [OPW-1:0] op_in,
  output logic [W-1:0]   res_out,
  output logic           err_out
);

  // Decode the opcode and compute the W-bit result.
  always_comb begin
    res_out = '0;
    err_out = 1'b0;
    case (op_in)
      OP_AND:  res_out = a_in & b_in;
      OP_OR:   res_out = a_in | b_in;
      OP_XOR:  res_out = a_in ^ b_in;
      OP_NAND: res_out = ~(a_in & b_in);
      OP_NOR:  res_out = ~(a_in | b_in);
      OP_XNOR: res_out = ~(a_in ^ b_in);
      OP_NOT:  res_out = ~a_in;
      default: begin
        res_out = '0;
        err_out = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bitwise_op_scheduler.sv
// Two-requester round-robin front end sharing one bitwise lane; one operation in flight.
module bitwise_op_scheduler
  import bitwise_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned OPW = OP_W
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           r0_valid_in,
  output logic           r0_ready_out,
  input  logic [W-1:0]   r0_a_in,
  input  logic [W-1:0]   r0_b_in,
  input  logic [OPW-1:0] r0_op_in,
  input  logic           r1_valid_in,
  output logic           r1_ready_out,
  input  logic [W-1:0]   r1_a_in,
  input  logic [W-1:0]   r1_b_in,
  input  logic [OPW-1:0] r1_op_in,
  output logic           res_valid_out,
  input  logic           res_ready_in,
  output logic [W-1:0]   res_data_out,
  output logic           res_id_out,
  output logic           res_err_out,
  output logic           busy_out
);

  state_t         r_state;
  state_t         w_next;
  logic           r_ptr;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [OPW-1:0] r_op;
  logic           r_id;
  logic [W-1:0]   r_data;
  logic           r_err;
  logic           r_res_id;
  logic           w_gnt0;
  logic           w_gnt1;
  logic [W-1:0]   w_lane_res;
  logic           w_lane_err;

  bitwise_lane #(
    .W   (W),
    .OPW (OPW)
  ) u_lane (
    .a_in    (r_a),
    .b_in    (r_b),
    .op_in   (r_op),
    .res_out (w_lane_res),
    .err_out (w_lane_err)
  );

  // Arbitration and next-state: one-hot grant only in IDLE, pointer breaks ties.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst_in) begin
          w_gnt0 = r0_valid_in & (~r1_valid_in | ~r_ptr);
          w_gnt1 = r1_valid_in & (~r0_valid_in | r_ptr);
        end
        if (w_gnt0 | w_gnt1) w_next = ST_EXEC;
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (res_ready_in) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Latch the granted requester's operands and id on accept.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_id <= 1'b0;
    end else if (w_gnt0) begin
      r_a  <= r0_a_in;
      r_b  <= r0_b_in;
      r_op <= r0_op_in;
      r_id <= 1'b0;
    end else if (w_gnt1) begin
      r_a  <= r1_a_in;
      r_b  <= r1_b_in;
      r_op <= r1_op_in;
      r_id <= 1'b1;
    end
  end

  // Capture the lane output in EXEC; held unchanged through RESP.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_data   <= '0;
      r_err    <= 1'b0;
      r_res_id <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_data   <= w_lane_res;
      r_err    <= w_lane_err;
      r_res_id <= r_id;
    end
  end

  // Round-robin pointer moves to the other requester when a result is consumed.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_ptr <= 1'b0;
    else if (r_state == ST_RESP && res_ready_in) r_ptr <= ~r_res_id;
  end

  assign r0_ready_out  = w_gnt0;
  assign r1_ready_out  = w_gnt1;
  assign res_valid_out = (r_state == ST_RESP);
  assign res_data_out  = r_data;
  assign res_id_out    = r_res_id;
  assign res_err_out   = r_err;
  assign busy_out      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bitwise_op_scheduler.sv
// Scoreboard bench: stimulus pushes expected results on accept, a monitor pops on consume.
module tb_bitwise_op_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       r0_valid_in = 1'b0;
  logic       r0_ready_out;
  logic [3:0] r0_a_in = '0;
  logic [3:0] r0_b_in = '0;
  logic [2:0] r0_op_in = '0;
  logic       r1_valid_in = 1'b0;
  logic       r1_ready_out;
  logic [3:0] r1_a_in = '0;
  logic [3:0] r1_b_in = '0;
  logic [2:0] r1_op_in = '0;
  logic       res_valid_out;
  logic       res_ready_in = 1'b0;
  logic [3:0] res_data_out;
  logic       res_id_out;
  logic       res_err_out;
  logic       busy_out;

  bitwise_op_scheduler #(.W(4), .OPW(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .r0_valid_in   (r0_valid_in),
    .r0_ready_out  (r0_ready_out),
    .r0_a_in       (r0_a_in),
    .r0_b_in       (r0_b_in),
    .r0_op_in      (r0_op_in),
    .r1_valid_in   (r1_valid_in),
    .r1_ready_out  (r1_ready_out),
    .r1_a_in       (r1_a_in),
    .r1_b_in       (r1_b_in),
    .r1_op_in      (r1_op_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_id_out    (res_id_out),
    .res_err_out   (res_err_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  data;
    logic        id;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  logic        m_ptr = 1'b0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic logic [3:0] ref_res(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(logic id, logic [3:0] a, logic [3:0] b, logic [2:0] op);
    exp_t e;
    e.data = ref_res(a, b, op);
    e.id   = id;
    e.err  = (op == 3'd7);
    e.acc  = cyc;
    q.push_back(e);
  endtask

  // One clock: check readies/busy at the negedge, record accepts, return at posedge+1.
  task automatic cycle(output bit acc0, output bit acc1);
    bit idle, e0, e1;
    @(negedge clk_in);
    idle = (q.size() == 0) && !rst_in;
    e0 = idle && r0_valid_in && (!r1_valid_in || !m_ptr);
    e1 = idle && r1_valid_in && (!r0_valid_in || m_ptr);
    check("r0_ready", 32'(r0_ready_out), 32'(e0));
    check("r1_ready", 32'(r1_ready_out), 32'(e1));
    if (!rst_in) check("busy", 32'(busy_out), 32'(q.size() != 0));
    acc0 = r0_valid_in && (r0_ready_out === 1'b1) && !rst_in;
    acc1 = r1_valid_in && (r1_ready_out === 1'b1) && !rst_in;
    if (acc0) push_exp(1'b0, r0_a_in, r0_b_in, r0_op_in);
    if (acc1) push_exp(1'b1, r1_a_in, r1_b_in, r1_op_in);
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(bit who, logic [3:0] a, logic [3:0] b, logic [2:0] op);
    bit a0, a1, done;
    done = 0;
    if (!who) begin
      r0_valid_in = 1'b1; r0_a_in = a; r0_b_in = b; r0_op_in = op;
    end else begin
      r1_valid_in = 1'b1; r1_a_in = a; r1_b_in = b; r1_op_in = op;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      cycle(a0, a1);
      done = who ? a1 : a0;
    end
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout: requester %0d not accepted, required accept within 50 cycles", who);
    end
    if (!who) r0_valid_in = 1'b0;
    else      r1_valid_in = 1'b0;
  endtask

  task automatic drain();
    bit a0, a1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(a0, a1);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic do_reset();
    bit a0, a1;
    rst_in = 1'b1;
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    q.delete();
    m_ptr = 1'b0;
    cycle(a0, a1);
    cycle(a0, a1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_res_valid", 32'(res_valid_out), 32'd0);
    check("rst_res_data",  32'(res_data_out),  32'd0);
    check("rst_res_id",    32'(res_id_out),    32'd0);
    check("rst_res_err",   32'(res_err_out),   32'd0);
    check("rst_busy",      32'(busy_out),      32'd0);
    check("rst_r0_ready",  32'(r0_ready_out),  32'd0);
    check("rst_r1_ready",  32'(r1_ready_out),  32'd0);
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: compares the presented result against the head of the scoreboard.
  initial begin
    bit seen;
    seen = 0;
    forever begin
      @(negedge clk_in);
      #1;
      if (res_valid_out === 1'b1) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL stale_result: res_valid_out=1 with data %0h, required no result", res_data_out);
        end else begin
          if (!seen) begin
            check("latency", cyc, q[0].acc + 2);
            seen = 1;
          end
          check("res_data", 32'(res_data_out), 32'(q[0].data));
          check("res_id",   32'(res_id_out),   32'(q[0].id));
          check("res_err",  32'(res_err_out),  32'(q[0].err));
          if (res_ready_in) begin
            m_ptr = ~q[0].id;
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    bit a0, a1;
    int unsigned g;

    do_reset();
    res_ready_in = 1'b1;

    // r0 only, AND
    issue(1'b0, 4'b0101, 4'b1011, 3'd0);
    // sweep ops 1..6 on r1
    for (int op = 1; op <= 6; op++) issue(1'b1, 4'b0101, 4'b1011, 3'(op));
    drain();

    // both valid continuously: grants alternate, r0 first after reset
    do_reset();
    res_ready_in = 1'b1;
    r0_valid_in = 1'b1; r0_a_in = 4'($urandom); r0_b_in = 4'($urandom); r0_op_in = 3'($urandom);
    r1_valid_in = 1'b1; r1_a_in = 4'($urandom); r1_b_in = 4'($urandom); r1_op_in = 3'($urandom);
    g = 0;
    for (int i = 0; i < 40 && g < 6; i++) begin
      cycle(a0, a1);
      if (a0 || a1) begin
        check("alt_grant", 32'(a1), 32'(g % 2));
        g++;
      end
      if (a0) begin r0_a_in = 4'($urandom); r0_b_in = 4'($urandom); r0_op_in = 3'($urandom); end
      if (a1) begin r1_a_in = 4'($urandom); r1_b_in = 4'($urandom); r1_op_in = 3'($urandom); end
    end
    check("alt_grant_count", g, 32'd6);
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    drain();

    // reserved opcode, then a normal op clears err
    issue(1'b1, 4'($urandom), 4'($urandom), 3'd7);
    issue(1'b1, 4'b1100, 4'b1010, 3'd2);
    drain();

    // result stall for 5 cycles in RESP with both requesters waiting
    res_ready_in = 1'b0;
    issue(1'b0, 4'b0110, 4'b0011, 3'd5);
    r0_valid_in = 1'b1; r0_a_in = 4'($urandom); r0_b_in = 4'($urandom); r0_op_in = 3'($urandom);
    r1_valid_in = 1'b1; r1_a_in = 4'($urandom); r1_b_in = 4'($urandom); r1_op_in = 3'($urandom);
    for (int i = 0; i < 6; i++) cycle(a0, a1);
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    res_ready_in = 1'b1;
    drain();

    // reset while EXEC: pointer is r1 here, reset must bring it back to r0
    issue(1'b0, 4'b1111, 4'b0001, 3'd0);
    drain();
    r0_valid_in = 1'b1; r0_a_in = 4'b1010; r0_b_in = 4'b0101; r0_op_in = 3'd1;
    r1_valid_in = 1'b1; r1_a_in = 4'b0011; r1_b_in = 4'b0110; r1_op_in = 3'd2;
    cycle(a0, a1);
    check("pre_rst_grant_r1", 32'(a1), 32'd1);
    rst_in = 1'b1;
    q.delete();
    m_ptr = 1'b0;
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    cycle(a0, a1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_res_valid", 32'(res_valid_out), 32'd0);
    check("post_rst_busy",      32'(busy_out),      32'd0);
    @(posedge clk_in);
    #1;
    r0_valid_in = 1'b1;
    r1_valid_in = 1'b1;
    cycle(a0, a1);
    check("post_rst_grant_r0", 32'(a0), 32'd1);
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    drain();

    // randomized traffic with random result back-pressure
    for (int i = 0; i < 400; i++) begin
      cycle(a0, a1);
      if (a0) r0_valid_in = 1'b0;
      if (a1) r1_valid_in = 1'b0;
      if (!r0_valid_in && $urandom_range(1, 0) == 1) begin
        r0_valid_in = 1'b1; r0_a_in = 4'($urandom); r0_b_in = 4'($urandom); r0_op_in = 3'($urandom);
      end
      if (!r1_valid_in && $urandom_range(1, 0) == 1) begin
        r1_valid_in = 1'b1; r1_a_in = 4'($urandom); r1_b_in = 4'($urandom); r1_op_in = 3'($urandom);
      end
      res_ready_in = ($urandom_range(2, 0) != 0);
    end
    r0_valid_in = 1'b0;
    r1_valid_in = 1'b0;
    res_ready_in = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
